// File: rtl/sat_sweep_ctrl_if.sv
// Bus interface for the saturation sweep sequencer.
// The master side drives start/stop; the slave side (the sequencer) returns
// the register value, its max/min flags, status bits and the state number.
`timescale 1ns/1ps

interface sat_sweep_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic [WIDTH:0]   regs;
  logic             at_max;
  logic             at_min;
  logic             busy;
  logic             done;
  logic [2:0]       state;

  modport master (
    output start, stop,
    input  regs, at_max, at_min, busy, done, state
  );

  modport slave (
    input  start, stop,
    output regs, at_max, at_min, busy, done, state
  );
endinterface

// File: rtl/sat_sweep_ctrl.sv
// Saturation-test register sequencer.
// Sweeps a (WIDTH+1)-bit register from zero up to all-ones one step per
// prescaler tick, holds, sweeps back down to zero, holds, then finishes.
// Steps clamp at both ends so the register never wraps.
// Optional feature macro: SAT_SWEEP_LOOP_EN -- when defined the sweep repeats
// forever (HOLD_MIN returns to RAMP_UP) and DONE is never entered; when
// undefined the sequencer parks in DONE after one sweep.
`timescale 1ns/1ps

module sat_sweep_ctrl #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE   = 25_000_000,
  parameter int HOLD_TICKS = 2
) (
  input  logic             clk,
  input  logic             reset,
  sat_sweep_ctrl_if.slave  bus
);

  localparam int RW = WIDTH + 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [RW-1:0] REG_MAX    = {RW{1'b1}};
  localparam logic [RW-1:0] REG_ONE    = RW'(1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_MAX  = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_MIN  = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   regs_q, regs_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tick;

  // Step tick: qualified by busy so the prescaler only produces ticks during a sweep.
  assign tick = busy_q && (presc_q == PRESC_LAST);

  // State register plus every datapath flop; reset returns everything to the idle picture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      regs_q  <= '0;
      presc_q <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state decision: stop overrides everything, start only matters when not sweeping.
  always_comb begin
    state_d = state_q;
    if (bus.stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) state_d = RAMP_UP;
        end
        RAMP_UP: begin
          if (tick && (regs_q == REG_MAX - REG_ONE)) state_d = HOLD_MAX;
        end
        HOLD_MAX: begin
          if (tick && (hold_q == HOLD_LAST)) state_d = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (tick && (regs_q == REG_ONE)) state_d = HOLD_MIN;
        end
        HOLD_MIN: begin
`ifdef SAT_SWEEP_LOOP_EN
          if (tick && (hold_q == HOLD_LAST)) state_d = RAMP_UP;
`else
          if (tick && (hold_q == HOLD_LAST)) state_d = DONE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and registered status: clamped stepping, hold counting, prescaler restart on each state entry.
  always_comb begin
    regs_d  = regs_q;
    hold_d  = hold_q;
    presc_d = '0;
    if (busy_q && !tick) presc_d = presc_q + PRESC_ONE;
    if (state_d != state_q) presc_d = '0;
    busy_d = (state_d == RAMP_UP) || (state_d == HOLD_MAX) ||
             (state_d == RAMP_DOWN) || (state_d == HOLD_MIN);
    done_d = (state_d == DONE);

    if (bus.stop) begin
      regs_d  = '0;
      hold_d  = '0;
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) regs_d = '0;
        end
        RAMP_UP: begin
          if (tick && (regs_q != REG_MAX)) regs_d = regs_q + REG_ONE;
        end
        RAMP_DOWN: begin
          if (tick && (regs_q != '0)) regs_d = regs_q - REG_ONE;
        end
        HOLD_MAX, HOLD_MIN: begin
          if (tick) hold_d = hold_q + HOLD_ONE;
        end
        default: ;
      endcase
      if ((state_d != state_q) && ((state_d == HOLD_MAX) || (state_d == HOLD_MIN))) hold_d = '0;
    end
  end

  assign bus.regs   = regs_q;
  assign bus.at_max = (regs_q == REG_MAX);
  assign bus.at_min = (regs_q == '0);
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_sat_sweep_ctrl.sv
// Self-checking bench for sat_sweep_ctrl.
// Two sequencers share one stimulus stream: one ticking every cycle and one
// every fourth cycle. A sweep-profile model (position in the sweep derived
// from elapsed cycles) predicts every output each cycle.
// Honours SAT_SWEEP_LOOP_EN the same way the design does.
`timescale 1ns/1ps

module tb_sat_sweep_ctrl;

  localparam int WIDTH       = 4;
  localparam int HOLD_TICKS  = 2;
  localparam int PRESC_FAST  = 1;
  localparam int PRESC_SLOW  = 4;
  localparam int MAXV        = (1 << (WIDTH + 1)) - 1;
  localparam int SWEEP_TICKS = 2 * MAXV + 2 * HOLD_TICKS;

  logic clk = 1'b0;
  logic reset;

  sat_sweep_ctrl_if #(.WIDTH(WIDTH)) bus_fast ();
  sat_sweep_ctrl_if #(.WIDTH(WIDTH)) bus_slow ();

  sat_sweep_ctrl #(.WIDTH(WIDTH), .PRESCALE(PRESC_FAST), .HOLD_TICKS(HOLD_TICKS)) dut_fast (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_fast)
  );

  sat_sweep_ctrl #(.WIDTH(WIDTH), .PRESCALE(PRESC_SLOW), .HOLD_TICKS(HOLD_TICKS)) dut_slow (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_slow)
  );

  always #5 clk = ~clk;

  // model: mode 0 = idle, 1 = sweeping, 2 = finished; elapsed = cycles since sweep start
  int mode[2];
  int elapsed[2];
  int presc_of[2];
  int checks = 0;
  int passed = 0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed == expected) passed++;
    else $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
  endtask

  function automatic void modelStep(input int k, input logic s, input logic p, input logic r);
    if (r || p) begin
      mode[k] = 0;
      elapsed[k] = 0;
    end else if (mode[k] != 1) begin
      if (s) begin
        mode[k] = 1;
        elapsed[k] = 0;
      end
    end else begin
      elapsed[k]++;
`ifndef SAT_SWEEP_LOOP_EN
      if (elapsed[k] / presc_of[k] >= SWEEP_TICKS) mode[k] = 2;
`endif
    end
  endfunction

  // Translate sweep position (ticks since start) into expected state number and register value.
  function automatic void modelView(input int k, output int e_state, output int e_regs);
    int t;
    if (mode[k] == 0) begin
      e_state = 0; e_regs = 0;
    end else if (mode[k] == 2) begin
      e_state = 5; e_regs = 0;
    end else begin
      t = (elapsed[k] / presc_of[k]) % SWEEP_TICKS;
      if (t < MAXV) begin
        e_state = 1; e_regs = t;
      end else if (t < MAXV + HOLD_TICKS) begin
        e_state = 2; e_regs = MAXV;
      end else if (t < 2 * MAXV + HOLD_TICKS) begin
        e_state = 3; e_regs = MAXV - (t - MAXV - HOLD_TICKS);
      end else begin
        e_state = 4; e_regs = 0;
      end
    end
  endfunction

  task automatic checkDut(input string name, input int k, input int o_regs, input int o_max,
                          input int o_min, input int o_busy, input int o_done, input int o_state);
    int e_state, e_regs;
    modelView(k, e_state, e_regs);
    checkOutput({name, ".state"},  o_state, e_state);
    checkOutput({name, ".regs"},   o_regs,  e_regs);
    checkOutput({name, ".at_max"}, o_max,   int'(e_regs == MAXV));
    checkOutput({name, ".at_min"}, o_min,   int'(e_regs == 0));
    checkOutput({name, ".busy"},   o_busy,  int'(mode[k] == 1));
    checkOutput({name, ".done"},   o_done,  int'(mode[k] == 2));
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic r);
    bus_fast.start = s; bus_slow.start = s;
    bus_fast.stop  = p; bus_slow.stop  = p;
    reset = r;
    @(posedge clk);
    modelStep(0, s, p, r);
    modelStep(1, s, p, r);
    #1;
    checkDut("fast", 0, int'(bus_fast.regs), int'(bus_fast.at_max), int'(bus_fast.at_min),
             int'(bus_fast.busy), int'(bus_fast.done), int'(bus_fast.state));
    checkDut("slow", 1, int'(bus_slow.regs), int'(bus_slow.at_max), int'(bus_slow.at_min),
             int'(bus_slow.busy), int'(bus_slow.done), int'(bus_slow.state));
  endtask

  initial begin
    int max_cycles;
    int e_state, e_regs;
    bit found;
    logic rs, ss, ps;

    presc_of[0] = PRESC_FAST;
    presc_of[1] = PRESC_SLOW;
    mode[0] = 0; mode[1] = 0;
    elapsed[0] = 0; elapsed[1] = 0;
    bus_fast.start = 1'b0; bus_slow.start = 1'b0;
    bus_fast.stop  = 1'b0; bus_slow.stop  = 1'b0;
    reset = 1'b1;

    // reset held three cycles, then idle
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);

    // single start pulse, full sweep on the fast unit
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("fast.busy_after_start", int'(bus_fast.busy), 1);
    max_cycles = 0;
    for (int j = 1; j <= 66; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (bus_fast.at_max) max_cycles++;
      if (j == 65) checkOutput("fast.done_before_66", int'(bus_fast.done), 0);
`ifdef SAT_SWEEP_LOOP_EN
      if (j == 66) checkOutput("fast.loop_state_66", int'(bus_fast.state), 1);
`else
      if (j == 66) checkOutput("fast.done_at_66", int'(bus_fast.done), 1);
`endif
    end
    checkOutput("fast.at_max_cycles", max_cycles, 3);

    // let the slow unit run its sweep to the end
    repeat (4 * SWEEP_TICKS) applyStimulus(1'b0, 1'b0, 1'b0);

    // stop in RAMP_UP at regs 17, then start+stop together from IDLE
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    found = 1'b0;
    for (int j = 0; j < 40 && !found; j++) begin
      modelView(0, e_state, e_regs);
      if (e_regs == 17 && e_state == 1) found = 1'b1;
      else applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("fast.reached_17", int'(bus_fast.regs), 17);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("fast.state_after_stop", int'(bus_fast.state), 0);
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0);

    // start held continuously across a whole sweep and into the next
    repeat (4 * SWEEP_TICKS + 10) applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);

    // random traffic: first stop-heavy, then long uninterrupted sweeps
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 499) == 0);
      ps = ($urandom_range(0, 999) < ((i < 1500) ? 30 : 2));
      ss = ($urandom_range(0, 9) < 3);
      applyStimulus(ss, ps, rs);
    end

    // mid-operation reset returns to the power-on picture
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (7) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("fast.regs_after_reset", int'(bus_fast.regs), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
